// File: rtl/bp_arbiter_pkg.sv
// ============================================================================
// Module   : bp_arbiter_pkg
// Purpose  : Shared types for the bytepipe arbiter. This covers the header
//            layout, the state encodings for both directions and the width
//            of the client id.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_arbiter_pkg;

  localparam int ID_W = 4;

  // Header byte layout, used in both directions
  typedef struct packed {
    logic [3:0]      len_m1;  // payload length minus one (1..16 bytes)
    logic [ID_W-1:0] id;      // client id
  } hdr_t;

  typedef enum logic [0:0] {H_HDR, H_PAY} h_state_t;
  typedef enum logic [1:0] {D_IDLE, D_COL, D_HDR, D_DRN} d_state_t;

endpackage

`default_nettype wire

// File: rtl/bp_arbiter_rr.sv
// ============================================================================
// Module   : bp_arbiter_rr
// Purpose  : N-way round-robin pick. The search starts at ptr_i, runs upward
//            and wraps to the bottom.
// Ports    : req_i   - request vector, one bit per client
//            ptr_i   - starting search position (0..N-1)
//            grant_o - one-hot grant; all zero when there is no request
//            idx_o   - index of the granted client
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_arbiter_rr
  import bp_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] idx_o
);

  logic w_found;

  // The first pass covers ptr..N-1. The second pass covers the wrap from 0,
  // and it does nothing if the first pass already made a pick.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && req_i[j] && (ID_W'(j) >= ptr_i)) begin
        grant_o[j] = 1'b1;
        idx_o      = ID_W'(j);
        w_found    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = ID_W'(j);
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_arbiter.sv
// ============================================================================
// Module   : bp_arbiter
// Purpose  : Shares one USB-serial bytepipe between N_CLIENT bytepipe clients.
//            Host->dev: a header routes the payload to one client, with zero
//            added latency. Dev->host: clients are granted round-robin. Each
//            burst is buffered, then sent behind a header.
// Config   : BP_ARBITER_DROPCNT_EN adds o_dropCount. It counts payload bytes
//            that the host sent to a non-existent client and saturates at 255.
// Ports    : i_clk, i_rst            clock, async active-high reset
//            i_hostToDev_*           bytes from USB
//            o_devToHost_*           bytes to USB
//            o_cl_* / i_cl_ready     host->client bytes, slice k = client k
//            i_cl_* / o_cl_ready     client->host bytes
//            o_dropCount             discarded byte count (optional)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_arbiter
  import bp_arbiter_pkg::*;
#(
  parameter int N_CLIENT     = 2,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_hostToDev_data,
  input  logic                  i_hostToDev_valid,
  output logic                  o_hostToDev_ready,
  output logic [7:0]            o_devToHost_data,
  output logic                  o_devToHost_valid,
  input  logic                  i_devToHost_ready,
  output logic [8*N_CLIENT-1:0] o_cl_data,
  output logic [N_CLIENT-1:0]   o_cl_valid,
  input  logic [N_CLIENT-1:0]   i_cl_ready,
  input  logic [8*N_CLIENT-1:0] i_cl_data,
  input  logic [N_CLIENT-1:0]   i_cl_valid,
  output logic [N_CLIENT-1:0]   o_cl_ready
`ifdef BP_ARBITER_DROPCNT_EN
  ,
  output logic [7:0]            o_dropCount
`endif
);

  localparam logic [ID_W-1:0] c_LAST = ID_W'(N_CLIENT - 1);
  localparam logic [4:0]      c_NCL  = 5'(N_CLIENT);
  localparam logic [4:0]      c_MAXB = 5'(MAX_BURST);
  localparam logic [7:0]      c_TMO  = 8'(IDLE_TIMEOUT);

  // --------------------------------------------------------------------------
  // Host -> device
  // --------------------------------------------------------------------------
  h_state_t        h_state_q, h_state_d;
  logic [ID_W-1:0] h_id_q, h_id_d;
  logic [4:0]      h_rem_q, h_rem_d;
  logic            run_q;     // keeps ready low through the reset cycle
  logic            w_h_known;
  logic            w_h_xfer;
  hdr_t            w_h_hdr;

  assign w_h_hdr   = hdr_t'(i_hostToDev_data);
  assign w_h_known = ({1'b0, h_id_q} < c_NCL);
  assign w_h_xfer  = i_hostToDev_valid && o_hostToDev_ready;

  always_comb begin
    o_cl_valid        = '0;
    o_cl_data         = '0;
    o_hostToDev_ready = 1'b0;
    if (h_state_q == H_HDR) begin
      o_hostToDev_ready = run_q;
    end else if (!w_h_known) begin
      o_hostToDev_ready = 1'b1;  // payload for a non-existent client is sunk
    end else begin
      for (int k = 0; k < N_CLIENT; k++) begin
        if (h_id_q == ID_W'(k)) begin
          o_cl_valid[k]        = i_hostToDev_valid;
          o_cl_data[8*k +: 8]  = i_hostToDev_data;
          o_hostToDev_ready    = i_cl_ready[k];
        end
      end
    end
  end

  always_comb begin
    h_state_d = h_state_q;
    h_id_d    = h_id_q;
    h_rem_d   = h_rem_q;
    if (w_h_xfer) begin
      if (h_state_q == H_HDR) begin
        h_id_d    = w_h_hdr.id;
        h_rem_d   = {1'b0, w_h_hdr.len_m1} + 5'd1;
        h_state_d = H_PAY;
      end else begin
        h_rem_d = h_rem_q - 5'd1;
        if (h_rem_q == 5'd1) h_state_d = H_HDR;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_state_q <= H_HDR;
      h_id_q    <= '0;
      h_rem_q   <= '0;
      run_q     <= 1'b0;
    end else begin
      h_state_q <= h_state_d;
      h_id_q    <= h_id_d;
      h_rem_q   <= h_rem_d;
      run_q     <= 1'b1;
    end
  end

`ifdef BP_ARBITER_DROPCNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drop_q <= '0;
    end else if (w_h_xfer && (h_state_q == H_PAY) && !w_h_known && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign o_dropCount = drop_q;
`endif

  // --------------------------------------------------------------------------
  // Device -> host
  // --------------------------------------------------------------------------
  d_state_t            d_state_q, d_state_d;
  logic [ID_W-1:0]     g_q, g_d;       // granted client
  logic [ID_W-1:0]     rr_q, rr_d;     // round-robin start pointer
  logic [4:0]          cnt_q, cnt_d;   // bytes buffered in this burst
  logic [3:0]          dr_q, dr_d;     // drain index
  logic [7:0]          idle_q, idle_d; // idle cycles since the last accepted byte
  logic [7:0]          buf_q [16];
  logic [N_CLIENT-1:0] w_rr_grant;
  logic [ID_W-1:0]     w_rr_idx;
  logic                w_rr_any;
  logic                w_c_valid;
  logic [7:0]          w_c_data;
  logic                w_c_xfer;
  logic [4:0]          w_cnt_m1;
  hdr_t                w_d_hdr;

  bp_arbiter_rr #(
    .N (N_CLIENT)
  ) u_rr (
    .req_i   (i_cl_valid),
    .ptr_i   (rr_q),
    .grant_o (w_rr_grant),
    .idx_o   (w_rr_idx)
  );

  assign w_rr_any = |w_rr_grant;

  always_comb begin
    w_c_valid  = 1'b0;
    w_c_data   = '0;
    o_cl_ready = '0;
    for (int k = 0; k < N_CLIENT; k++) begin
      if (g_q == ID_W'(k)) begin
        w_c_valid     = i_cl_valid[k];
        w_c_data      = i_cl_data[8*k +: 8];
        o_cl_ready[k] = (d_state_q == D_COL);
      end
    end
  end

  assign w_c_xfer       = w_c_valid && (d_state_q == D_COL);
  assign w_cnt_m1       = cnt_q - 5'd1;
  assign w_d_hdr.len_m1 = w_cnt_m1[3:0];
  assign w_d_hdr.id     = g_q;

  // The outputs decode from registers only, so they stay stable under USB backpressure
  always_comb begin
    o_devToHost_valid = 1'b0;
    o_devToHost_data  = '0;
    case (d_state_q)
      D_HDR: begin
        o_devToHost_valid = 1'b1;
        o_devToHost_data  = w_d_hdr;
      end
      D_DRN: begin
        o_devToHost_valid = 1'b1;
        o_devToHost_data  = buf_q[dr_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    d_state_d = d_state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    dr_d      = dr_q;
    idle_d    = idle_q;
    case (d_state_q)
      D_IDLE: begin
        if (w_rr_any) begin
          g_d       = w_rr_idx;
          cnt_d     = '0;
          idle_d    = '0;
          d_state_d = D_COL;
        end
      end
      D_COL: begin
        if (w_c_xfer) begin
          cnt_d  = cnt_q + 5'd1;
          idle_d = '0;
          if (cnt_q + 5'd1 == c_MAXB) d_state_d = D_HDR;
        end else if (cnt_q != 5'd0) begin
          // An empty burst waits forever; only a started burst times out
          idle_d = idle_q + 8'd1;
          if (idle_q + 8'd1 == c_TMO) d_state_d = D_HDR;
        end
      end
      D_HDR: begin
        if (i_devToHost_ready) begin
          dr_d      = '0;
          d_state_d = D_DRN;
        end
      end
      D_DRN: begin
        if (i_devToHost_ready) begin
          dr_d = dr_q + 4'd1;
          if ({1'b0, dr_q} == w_cnt_m1) begin
            d_state_d = D_IDLE;
            rr_d      = (g_q == c_LAST) ? '0 : g_q + 1'b1;
          end
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_state_q <= D_IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      dr_q      <= '0;
      idle_q    <= '0;
    end else begin
      d_state_q <= d_state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      dr_q      <= dr_d;
      idle_q    <= idle_d;
    end
  end

  // Buffer contents only matter below cnt_q, so they need no reset
  always_ff @(posedge i_clk) begin
    if (w_c_xfer) buf_q[cnt_q[3:0]] <= w_c_data;
  end

endmodule

`default_nettype wire
